sized_data_memory: RTL and testbench

- Parametrised successor to the single-cycle word `Memory`: a word-organised data memory for the MIPS datapath.
- Adds MIPS-sized accesses (byte/half/word), sign/zero-extending loads, and byte-lane stores.
- Reads complete after a configurable latency under a valid/ready handshake.
- Misaligned or out-of-range accesses are flagged instead of silently aliasing.

---
 rtl/sized_data_memory.sv | 181 ++++++++++++++++++
 tb/tb_sized_data_memory.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sized_data_memory.sv
// Word-organised MIPS data memory with byte/half/word accesses, big-endian lanes,
// sign/zero-extending loads, a valid/ready handshake and a configurable read latency.
module sized_data_memory #(
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        writeEnable,
    input  logic [31:0] Address,
    input  logic [1:0]  size,
    input  logic        signedLoad,
    input  logic [31:0] writeData,
    output logic [31:0] MemData,
    output logic        dataValid,
    output logic        error
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;

    logic [31:0] mem [DEPTH_WORDS];

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rd_word_q, rd_word_d;
    logic [1:0]    rd_lane_q, rd_lane_d;
    size_e         rd_size_q, rd_size_d;
    logic          rd_signed_q, rd_signed_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic          data_valid_q, data_valid_d;
    logic          error_q, error_d;

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    size_e         req_size;
    logic          out_of_range;
    logic          req_error;
    logic          accept;
    logic          wr_en;
    logic [31:0]   wr_mask;
    logic [31:0]   wr_word;

    assign word_idx     = Address[2 +: AW];
    assign lane         = Address[1:0];
    assign req_size     = size_e'(size);
    assign out_of_range = |(Address >> (AW + 2));
    assign reqReady     = (state_q == IDLE);
    assign accept       = reqValid && reqReady;
    assign wr_en        = accept && writeEnable && !req_error && !Reset;

    assign MemData   = mem_data_q;
    assign dataValid = data_valid_q;
    assign error     = error_q;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] ln,
                                                input size_e sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{~ln, 3'b000} +: 8];
        h = ln[1] ? word[15:0] : word[31:16];
        case (sz)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_error = out_of_range;
        case (req_size)
            SZ_BYTE: req_error = out_of_range;
            SZ_HALF: req_error = out_of_range | Address[0];
            SZ_WORD: req_error = out_of_range | (|Address[1:0]);
            default: req_error = 1'b1;
        endcase
    end

    // Store data is replicated across lanes; the mask picks which lanes actually change.
    always_comb begin
        wr_mask = '0;
        wr_word = writeData;
        case (req_size)
            SZ_BYTE: begin
                wr_mask = 32'hFF00_0000 >> {lane, 3'b000};
                wr_word = {4{writeData[7:0]}};
            end
            SZ_HALF: begin
                wr_mask = lane[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                wr_word = {2{writeData[15:0]}};
            end
            SZ_WORD: wr_mask = 32'hFFFF_FFFF;
            default: wr_mask = '0;
        endcase
    end

    // NOTE: the storage array has no reset; only control state is cleared, contents persist.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[word_idx] <= (mem[word_idx] & ~wr_mask) | (wr_word & wr_mask);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_word_d    = rd_word_q;
        rd_lane_d    = rd_lane_q;
        rd_size_d    = rd_size_q;
        rd_signed_d  = rd_signed_q;
        mem_data_d   = mem_data_q;
        data_valid_d = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_error) begin
                        error_d = 1'b1;
                    end else if (!writeEnable) begin
                        state_d     = BUSY;
                        cnt_d       = CNT_INIT;
                        rd_word_d   = mem[word_idx];
                        rd_lane_d   = lane;
                        rd_size_d   = req_size;
                        rd_signed_d = signedLoad;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The result is registered on the edge where the counter lands on zero, so
        // dataValid is seen in the last busy cycle, READ_LATENCY cycles after accept.
        if ((state_q == BUSY && cnt_q == CW'(1)) ||
            (state_q == IDLE && state_d == BUSY && CNT_INIT == '0)) begin
            data_valid_d = 1'b1;
            mem_data_d   = extend_load(rd_word_d, rd_lane_d, rd_size_d, rd_signed_d);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_word_q    <= '0;
            rd_lane_q    <= '0;
            rd_size_q    <= SZ_BYTE;
            rd_signed_q  <= 1'b0;
            mem_data_q   <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_word_q    <= rd_word_d;
            rd_lane_q    <= rd_lane_d;
            rd_size_q    <= rd_size_d;
            rd_signed_q  <= rd_signed_d;
            mem_data_q   <= mem_data_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_sized_data_memory.sv
// Randomised and directed bench for sized_data_memory: one instance at READ_LATENCY=1,
// one at READ_LATENCY=3, both checked against a byte-level reference memory.
module tb_sized_data_memory;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst           [2];
    logic        req_valid     [2];
    logic        req_ready     [2];
    logic        write_enable  [2];
    logic [31:0] address       [2];
    logic [1:0]  req_size      [2];
    logic        signed_load   [2];
    logic [31:0] write_data    [2];
    logic [31:0] mem_data      [2];
    logic        data_valid    [2];
    logic        err_o         [2];

    logic [31:0] ref_mem [2][DEPTH];
    logic [31:0] last_md [2];
    int n_vec = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sized_data_memory #(
            .DEPTH_WORDS (DEPTH),
            .READ_LATENCY(g == 0 ? 1 : 3)
        ) u_dut (
            .Clk        (clk),
            .Reset      (rst[g]),
            .reqValid   (req_valid[g]),
            .reqReady   (req_ready[g]),
            .writeEnable(write_enable[g]),
            .Address    (address[g]),
            .size       (req_size[g]),
            .signedLoad (signed_load[g]),
            .writeData  (write_data[g]),
            .MemData    (mem_data[g]),
            .dataValid  (data_valid[g]),
            .error      (err_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit ref_err(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
        return addr >= 32'(4 * DEPTH);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Big-endian: byte k of the word (k = address mod 4) sits at bit 8*(3-k).
    function automatic logic [31:0] ref_load(input int d, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] w, v;
        int n, first;
        w = ref_mem[d][addr / 4];
        n = nbytes(sz);
        first = int'(addr % 4);
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | ((w >> (8 * (3 - (first + i)))) & 32'hFF);
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input int d, input logic [31:0] addr, input logic [1:0] sz,
                             input logic [31:0] wd);
        logic [31:0] w, bv;
        int n, ln;
        w = ref_mem[d][addr / 4];
        n = nbytes(sz);
        for (int i = 0; i < n; i++) begin
            ln = int'(addr % 4) + i;
            bv = (wd >> (8 * (n - 1 - i))) & 32'hFF;
            w = (w & ~(32'hFF << (8 * (3 - ln)))) | (bv << (8 * (3 - ln)));
        end
        ref_mem[d][addr / 4] = w;
    endtask

    task automatic wait_ready(input int d);
        for (int i = 0; i < 8 && req_ready[d] !== 1'b1; i++) @(negedge clk);
        check("ready_before_req", 32'(req_ready[d]), 32'd1);
    endtask

    // Called at the negedge of the first cycle after a load accept; returns at the
    // negedge of the cycle after the load has completed.
    task automatic expect_load(input int d, input logic [31:0] exp);
        for (int k = 1; k <= lat_of(d); k++) begin
            check("ld_busy_ready", 32'(req_ready[d]), 32'd0);
            check("ld_valid_timing", 32'(data_valid[d]), 32'(k == lat_of(d)));
            if (k < lat_of(d)) @(negedge clk);
        end
        check("ld_data", mem_data[d], exp);
        last_md[d] = exp;
        @(negedge clk);
        check("ld_ready_back", 32'(req_ready[d]), 32'd1);
        check("ld_valid_off", 32'(data_valid[d]), 32'd0);
    endtask

    task automatic scramble_fields(input int d);
        write_enable[d] = 1'($urandom);
        address[d]      = $urandom;
        req_size[d]     = 2'($urandom);
        signed_load[d]  = 1'($urandom);
        write_data[d]   = $urandom;
    endtask

    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [1:0] sz, input logic sg, input logic [31:0] wd);
        bit er;
        logic [31:0] exp;
        er = ref_err(addr, sz);
        exp = (!we && !er) ? ref_load(d, addr, sz, sg) : 32'h0;
        req_valid[d] = 1'b1; write_enable[d] = we; address[d] = addr;
        req_size[d] = sz; signed_load[d] = sg; write_data[d] = wd;
        wait_ready(d);
        @(posedge clk);
        if (we && !er) ref_store(d, addr, sz, wd);
        @(negedge clk);
        req_valid[d] = 1'b0;
        scramble_fields(d);
        if (er) begin
            check("err_pulse", 32'(err_o[d]), 32'd1);
            check("err_no_valid", 32'(data_valid[d]), 32'd0);
            check("err_memdata_held", mem_data[d], last_md[d]);
            check("err_ready", 32'(req_ready[d]), 32'd1);
            @(negedge clk);
            check("err_one_cycle", 32'(err_o[d]), 32'd0);
        end else if (we) begin
            check("st_no_valid", 32'(data_valid[d]), 32'd0);
            check("st_no_err", 32'(err_o[d]), 32'd0);
            check("st_ready", 32'(req_ready[d]), 32'd1);
        end else begin
            check("ld_no_err", 32'(err_o[d]), 32'd0);
            expect_load(d, exp);
        end
    endtask

    task automatic rand_req(input int d);
        logic [31:0] a;
        a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 4 * DEPTH - 1)) : $urandom;
        do_req(d, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom);
    endtask

    initial begin
        logic [31:0] e1, e2;
        bit seen_dv;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; write_enable[d] = 1'b0; address[d] = '0;
            req_size[d] = '0; signed_load[d] = 1'b0; write_data[d] = '0; last_md[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(req_ready[d]), 32'd1);
            check("rst_valid", 32'(data_valid[d]), 32'd0);
            check("rst_error", 32'(err_o[d]), 32'd0);
            check("rst_memdata", mem_data[d], 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) do_req(d, 1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom);

        // Latency-1 instance: round trip, byte/half lanes, error cases.
        do_req(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        do_req(0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080);
        do_req(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        do_req(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
        do_req(0, 1'b0, 32'h10, 2'd0, 1'b1, 32'h0);
        do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        do_req(0, 1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_8001);
        do_req(0, 1'b0, 32'h22, 2'd1, 1'b1, 32'h0);
        do_req(0, 1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
        do_req(0, 1'b0, 32'h20, 2'd1, 1'b0, 32'h0);
        do_req(0, 1'b0, 32'h02, 2'd2, 1'b0, 32'h0);
        do_req(0, 1'b1, 32'h05, 2'd1, 1'b0, 32'h0000_1234);
        do_req(0, 1'b0, 32'h04, 2'd2, 1'b0, 32'h0);
        do_req(0, 1'b1, 32'h400, 2'd2, 1'b0, 32'h5555_5555);
        do_req(0, 1'b0, 32'h00, 2'd2, 1'b0, 32'h0);
        do_req(0, 1'b0, 32'h08, 2'd3, 1'b0, 32'h0);
        do_req(0, 1'b1, 32'h08, 2'd3, 1'b0, 32'hFFFF_FFFF);
        do_req(0, 1'b0, 32'h08, 2'd2, 1'b0, 32'h0);

        // Back-to-back stores: reqValid held across two accepts.
        req_valid[0] = 1'b1; write_enable[0] = 1'b1; address[0] = 32'h30;
        req_size[0] = 2'd2; write_data[0] = 32'h1111_2222;
        @(posedge clk);
        ref_store(0, 32'h30, 2'd2, 32'h1111_2222);
        @(negedge clk);
        check("b2b_ready", 32'(req_ready[0]), 32'd1);
        address[0] = 32'h31; req_size[0] = 2'd0; write_data[0] = 32'h0000_00AB;
        @(posedge clk);
        ref_store(0, 32'h31, 2'd0, 32'h0000_00AB);
        @(negedge clk);
        req_valid[0] = 1'b0;
        do_req(0, 1'b0, 32'h30, 2'd2, 1'b0, 32'h0);

        // Latency-3 instance: reqValid held through the busy window.
        e1 = ref_load(1, 32'h40, 2'd2, 1'b0);
        e2 = ref_load(1, 32'h46, 2'd1, 1'b1);
        req_valid[1] = 1'b1; write_enable[1] = 1'b0; address[1] = 32'h40; req_size[1] = 2'd2;
        wait_ready(1);
        @(posedge clk);
        @(negedge clk);
        address[1] = 32'h46; req_size[1] = 2'd1; signed_load[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check("bp_busy_ready", 32'(req_ready[1]), 32'd0);
            check("bp_valid_timing", 32'(data_valid[1]), 32'(k == 3));
            if (k < 3) @(negedge clk);
        end
        check("bp_first_data", mem_data[1], e1);
        @(negedge clk);
        check("bp_ready_again", 32'(req_ready[1]), 32'd1);
        check("bp_first_valid_off", 32'(data_valid[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        expect_load(1, e2);

        // Reset one cycle after a load accept.
        do_req(1, 1'b1, 32'h80, 2'd2, 1'b0, 32'hCAFE_F00D);
        req_valid[1] = 1'b1; write_enable[1] = 1'b0; address[1] = 32'h84; req_size[1] = 2'd2;
        wait_ready(1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        last_md[1] = '0;
        check("rstmid_ready", 32'(req_ready[1]), 32'd1);
        check("rstmid_memdata", mem_data[1], 32'd0);
        seen_dv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_dv |= (data_valid[1] !== 1'b0) || (err_o[1] !== 1'b0);
            @(negedge clk);
        end
        check("rstmid_no_response", 32'(seen_dv), 32'd0);
        do_req(1, 1'b0, 32'h80, 2'd2, 1'b0, 32'h0);

        // Reset and a store request in the same cycle: the store must not land.
        rst[1] = 1'b1; req_valid[1] = 1'b1; write_enable[1] = 1'b1;
        address[1] = 32'h80; req_size[1] = 2'd2; write_data[1] = 32'h0BAD_0BAD;
        @(negedge clk);
        rst[1] = 1'b0; req_valid[1] = 1'b0;
        check("rstreq_no_err", 32'(err_o[1]), 32'd0);
        do_req(1, 1'b0, 32'h80, 2'd2, 1'b0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            rand_req(0);
            rand_req(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
